// File: rtl/instruction_queue.sv
// instruction_queue: DEPTH-entry circular-buffer instruction FIFO with a
// registered head word, opcode field, occupancy count and sticky overflow.
// Optional feature: define IR_FLUSH_EN to add the synchronous i_flush port.
module instruction_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_load,
  input  logic                       i_advance,
`ifdef IR_FLUSH_EN
  input  logic                       i_flush,
`endif
  output logic [WIDTH-1:0]           o_instruction,
  output logic [3:0]                 o_opcode,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_valid;
  logic             r_full;
  logic [WIDTH-1:0] r_instruction;

  logic             w_adv_ok;
  logic             w_load_ok;
  logic             w_write;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_overflow_nxt;
  logic [WIDTH-1:0] w_instruction_nxt;

  // Next-state: acceptance, pointer/count update and the head word seen after the edge
  always_comb begin
    w_adv_ok          = i_advance && (r_count != '0);
    w_load_ok         = i_load && (!r_full || w_adv_ok);
    w_write           = w_load_ok;
    w_wr_ptr_nxt      = w_load_ok ? PW'(r_wr_ptr + PW'(1)) : r_wr_ptr;
    w_rd_ptr_nxt      = w_adv_ok  ? PW'(r_rd_ptr + PW'(1)) : r_rd_ptr;
    w_overflow_nxt    = r_overflow | (i_load && r_full && !i_advance);
    w_count_nxt       = r_count;
    w_instruction_nxt = '0;

    case ({w_load_ok, w_adv_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    // New head is the word being written this edge when the read pointer lands on the write slot
    if (w_count_nxt == '0) begin
      w_instruction_nxt = '0;
    end else if (w_load_ok && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_instruction_nxt = i_data;
    end else begin
      w_instruction_nxt = r_mem[w_rd_ptr_nxt];
    end

`ifdef IR_FLUSH_EN
    // Flush wins over load/advance and keeps the sticky overflow as it was
    if (i_flush) begin
      w_write           = 1'b0;
      w_wr_ptr_nxt      = '0;
      w_rd_ptr_nxt      = '0;
      w_count_nxt       = '0;
      w_overflow_nxt    = r_overflow;
      w_instruction_nxt = '0;
    end
`endif
  end

  // Control state and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_valid       <= 1'b0;
      r_full        <= 1'b0;
      r_instruction <= '0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_overflow    <= w_overflow_nxt;
      r_valid       <= (w_count_nxt != '0);
      r_full        <= (w_count_nxt == CW'(DEPTH));
      r_instruction <= w_instruction_nxt;
    end
  end

  // Storage array; contents are never exposed while the queue is empty, so no reset
  always_ff @(posedge i_clk) begin
    if (w_write && i_rst_n) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_instruction = r_instruction;
  assign o_opcode      = r_instruction[WIDTH-1 -: 4];
  assign o_valid       = r_valid;
  assign o_full        = r_full;
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (WIDTH=16, DEPTH=4).
// Status vector compared in each check: {valid, full, count[2:0], overflow, instruction[15:0]}.
module tb_instruction_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        load;
  logic        advance;
`ifdef IR_FLUSH_EN
  logic        flush;
`endif
  logic [15:0] instruction;
  logic [3:0]  opcode;
  logic        valid;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int errors;
  int checks;

  instruction_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data        (data),
    .i_load        (load),
    .i_advance     (advance),
`ifdef IR_FLUSH_EN
    .i_flush       (flush),
`endif
    .o_instruction (instruction),
    .o_opcode      (opcode),
    .o_valid       (valid),
    .o_full        (full),
    .o_count       (count),
    .o_overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; advance = 1'b0; data = 16'h0000;
    #3;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", {valid, full, count, overflow, instruction}, 22'h0);
    end
    // Inputs held active while reset is low are ignored
    data = 16'h1234; load = 1'b1;
    tick();
    checks++;
    if ({valid, count, instruction} !== {1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_ignores_load: got v=%b c=%0d i=%h want v=0 c=0 i=0000", valid, count, instruction);
    end
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    data = 16'h208A; load = 1'b1;
    tick();
    load = 1'b0; data = 16'hFFFF;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b0, 3'd1, 1'b0, 16'h208A}) begin
      errors++;
      $display("FAIL single_load: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b0, 3'd1, 1'b0, 16'h208A});
    end
    checks++;
    if (opcode !== 4'h2) begin
      errors++;
      $display("FAIL single_opcode: got %h want 2", opcode);
    end
    tick(); tick();
    checks++;
    if (instruction !== 16'h208A) begin
      errors++;
      $display("FAIL idle_hold: got %h want 208a", instruction);
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL single_drain: got %h want 0", {valid, full, count, overflow, instruction});
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      data = 16'(16'h1001 + i); load = 1'b1;
      tick();
    end
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b1, 3'd4, 1'b0, 16'h1001}) begin
      errors++;
      $display("FAIL fill_full: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b1, 3'd4, 1'b0, 16'h1001});
    end
    data = 16'h1005;
    tick();
    load = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b1, 3'd4, 1'b1, 16'h1001}) begin
      errors++;
      $display("FAIL refused_load: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b1, 3'd4, 1'b1, 16'h1001});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instruction !== 16'(16'h1001 + i) || count !== 3'(4 - i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: got i=%h c=%0d want i=%h c=%0d", i, instruction, count,
                 16'(16'h1001 + i), 4 - i);
      end
      advance = 1'b1;
      tick();
      advance = 1'b0;
    end
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL drain_empty: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000});
    end
  endtask

  task automatic test_back_to_back_full();
    logic [15:0] exp_head;
    for (int i = 0; i < 4; i++) begin
      data = 16'(16'h1001 + i); load = 1'b1;
      tick();
    end
    data = 16'h3333; load = 1'b1; advance = 1'b1;
    tick();
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b1, 3'd4, 1'b1, 16'h1002}) begin
      errors++;
      $display("FAIL full_load_adv: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b1, 3'd4, 1'b1, 16'h1002});
    end
    // Three full passes around the ring with simultaneous load/advance
    for (int j = 1; j <= 12; j++) begin
      data = 16'(16'h5000 + j - 1);
      tick();
      case (j)
        1:       exp_head = 16'h1003;
        2:       exp_head = 16'h1004;
        3:       exp_head = 16'h3333;
        default: exp_head = 16'(16'h5000 + j - 4);
      endcase
      checks++;
      if (instruction !== exp_head || count !== 3'd4 || full !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pass[%0d]: got i=%h c=%0d f=%b want i=%h c=4 f=1", j, instruction, count,
                 full, exp_head);
      end
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instruction !== 16'(16'h5008 + i)) begin
        errors++;
        $display("FAIL wrap_drain[%0d]: got %h want %h", i, instruction, 16'(16'h5008 + i));
      end
      tick();
    end
    advance = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_empty: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000});
    end
  endtask

  task automatic test_empty_load_advance();
    data = 16'h4444; load = 1'b1; advance = 1'b1;
    tick();
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b0, 3'd1, 1'b1, 16'h4444}) begin
      errors++;
      $display("FAIL empty_load_adv: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b0, 3'd1, 1'b1, 16'h4444});
    end
    data = 16'h5555;
    tick();
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b0, 3'd1, 1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL single_load_adv: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b0, 3'd1, 1'b1, 16'h5555});
    end
    load = 1'b0;
    tick();
    tick();
    advance = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL adv_on_empty: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000});
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      data = 16'(16'h00A1 + i); load = 1'b1;
      tick();
    end
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b0, 3'd3, 1'b1, 16'h00A1}) begin
      errors++;
      $display("FAIL pre_reset: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b0, 3'd3, 1'b1, 16'h00A1});
    end
    data = 16'hBEEF; advance = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {valid, full, count, overflow, instruction});
    end
    tick();
    checks++;
    if ({valid, count, instruction} !== {1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_hold: got v=%b c=%0d i=%h want v=0 c=0 i=0000", valid, count, instruction);
    end
    load = 1'b0; advance = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; data = 16'h7777; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b0, 3'd1, 1'b0, 16'h7777}) begin
      errors++;
      $display("FAIL post_reset_load: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b0, 3'd1, 1'b0, 16'h7777});
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

`ifdef IR_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      data = 16'(16'h0001 + i); load = 1'b1;
      tick();
    end
    load = 1'b0; advance = 1'b1;
    tick(); tick();
    advance = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b1, 1'b0, 3'd2, 1'b1, 16'h0003}) begin
      errors++;
      $display("FAIL pre_flush: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b1, 1'b0, 3'd2, 1'b1, 16'h0003});
    end
    flush = 1'b1; load = 1'b1; data = 16'h9999;
    tick();
    flush = 1'b0; load = 1'b0;
    checks++;
    if ({valid, full, count, overflow, instruction} !== {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL flush: got %h want %h", {valid, full, count, overflow, instruction},
               {1'b0, 1'b0, 3'd0, 1'b1, 16'h0000});
    end
    data = 16'hABCD; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if ({valid, count, instruction} !== {1'b1, 3'd1, 16'hABCD}) begin
      errors++;
      $display("FAIL post_flush_load: got v=%b c=%0d i=%h want v=1 c=1 i=abcd", valid, count, instruction);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
`ifdef IR_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_single_load();
    test_fill_overflow();
    test_back_to_back_full();
    test_empty_load_advance();
    test_async_reset();
`ifdef IR_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
